// File: rtl/booth_divider_if.sv
// booth_divider_if: request/response bundle for the booth_divider block.
// Handshake: the requester holds N and D with start=1 across a rising edge
// while busy=0; that edge launches the division. The block answers with a
// single-cycle ready pulse in the cycle Q, R and div_zero are updated. No
// back-pressure exists; start seen while busy=1 is dropped, not queued.
interface booth_divider_if;
   logic              start;
   logic signed [7:0] N;
   logic signed [3:0] D;
   logic signed [7:0] Q;
   logic signed [3:0] R;
   logic              ready;
   logic              busy;
   logic              div_zero;

   modport master (output start, N, D, input Q, R, ready, busy, div_zero);
   modport slave  (input start, N, D, output Q, R, ready, busy, div_zero);
endinterface

// File: rtl/booth_divider.sv
// booth_divider: signed 8-bit / 4-bit restoring divider, one quotient bit
// per cycle, MSB first, on magnitudes with a final sign correction.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// Optional macro DIV_ZERO_DETECT_EN: D=0 finishes immediately with
// Q=0, R=0 and div_zero=1. Without it D=0 runs the normal 8 steps.
module booth_divider (
   input  logic             clock,
   input  logic             reset,
   booth_divider_if.slave   bus,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] nmag;      // dividend magnitude, shifted out MSB first
   logic [3:0] dmag;      // divisor magnitude (8 fits for D=-8)
   logic       sn;
   logic       sd;
   logic [3:0] rem;
   logic [7:0] qmag;
   logic [3:0] count;
   logic [7:0] q_r;
   logic [3:0] r_r;
   logic       ready_r;
   logic [4:0] partial;
   logic       ge;
   logic [3:0] rem_next;

`ifdef DIV_ZERO_DETECT_EN
   logic       dz_r;
   logic       dz_pend;
   assign bus.div_zero = dz_r;
`else
   assign bus.div_zero = 1'b0;
`endif

   assign bus.Q     = q_r;
   assign bus.R     = r_r;
   assign bus.ready = ready_r;
   assign bus.busy  = (state != IDLE);
   assign dbg_state = state;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // With dmag=0 this keeps subtracting nothing, so rem becomes |N|[3:0].
   always_comb begin
      partial  = {rem, nmag[7]};
      ge       = (partial >= {1'b0, dmag});
      rem_next = ge ? 4'(partial - {1'b0, dmag}) : partial[3:0];
   end

   // Control FSM plus datapath registers and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         nmag    <= 8'd0;
         dmag    <= 4'd0;
         sn      <= 1'b0;
         sd      <= 1'b0;
         rem     <= 4'd0;
         qmag    <= 8'd0;
         count   <= 4'd0;
         q_r     <= 8'd0;
         r_r     <= 4'd0;
         ready_r <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         dz_r    <= 1'b0;
         dz_pend <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ready_r <= 1'b0;
               if (bus.start) begin
                  sn    <= bus.N[7];
                  sd    <= bus.D[3];
                  nmag  <= bus.N[7] ? 8'(-bus.N) : bus.N;
                  dmag  <= bus.D[3] ? 4'(-bus.D) : bus.D;
                  rem   <= 4'd0;
                  qmag  <= 8'd0;
                  count <= 4'd8;
`ifdef DIV_ZERO_DETECT_EN
                  if (bus.D == 4'sd0) begin
                     dz_pend <= 1'b1;
                     state   <= DONE;
                  end else begin
                     dz_pend <= 1'b0;
                     state   <= RUN;
                  end
`else
                  state <= RUN;
`endif
               end
            end
            RUN: begin
               rem   <= rem_next;
               qmag  <= {qmag[6:0], ge};
               nmag  <= {nmag[6:0], 1'b0};
               count <= count - 4'd1;
               if (count == 4'd1) state <= DONE;
            end
            DONE: begin
               ready_r <= 1'b1;
               state   <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
               if (dz_pend) begin
                  q_r  <= 8'd0;
                  r_r  <= 4'd0;
                  dz_r <= 1'b1;
               end else begin
                  q_r  <= (sn ^ sd) ? 8'(-qmag) : qmag;
                  r_r  <= sn ? 4'(-rem) : rem;
                  dz_r <= 1'b0;
               end
`else
               q_r <= (sn ^ sd) ? 8'(-qmag) : qmag;
               r_r <= sn ? 4'(-rem) : rem;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/booth_divider.md
BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 The block SHALL have port N, input, signed 8 bits: the dividend.
REQ-005 The block SHALL have port D, input, signed 4 bits: the divisor.
REQ-006 The block SHALL have port Q, output reg, signed 8 bits: the quotient.
REQ-007 The block SHALL have port R, output reg, signed 4 bits: the remainder.
REQ-008 The block SHALL have port ready, output reg, 1 bit: one-cycle pulse when Q and R are updated.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port div_zero, output reg, 1 bit: the divide-by-zero flag (see Configuration).

Function
REQ-011 The block SHALL have the states IDLE, RUN and DONE.
REQ-012 IDLE SHALL clear ready; start=1 SHALL register N and D, load the |N| and |D| magnitudes and the sign bits, set count=8 and go to RUN.
REQ-013 RUN SHALL do one restoring step per cycle, MSB first: partial remainder = {rem, next magnitude bit}.
REQ-014 In each RUN step, if the partial remainder is >= |D|, the block SHALL subtract |D| and set the quotient bit to 1; otherwise it SHALL set the quotient bit to 0. count SHALL decrement each step.
REQ-015 RUN SHALL go to DONE on the step where count==1, giving exactly 8 iterations.
REQ-016 DONE SHALL register Q = (sign N xor sign D) ? -qmag : qmag, truncated toward zero.
REQ-017 DONE SHALL register R = sign N ? -rmag : rmag, so the remainder takes the sign of the dividend.
REQ-018 DONE SHALL set ready=1 and return to IDLE.
REQ-019 Latency: if the start edge is E0, Q, R and ready SHALL update at E9, and ready SHALL fall at E10.
REQ-020 The invariant N == Q*D + R SHALL hold for all D != 0, except for REQ-021.
REQ-021 Overflow: N=-128, D=-1 SHALL produce Q=8'h80 (wrapped) and R=0, with no flag.
REQ-022 D=-8 SHALL be handled with a 4-bit unsigned magnitude of 8; N=-128 SHALL use an 8-bit unsigned magnitude of 128.
REQ-023 start asserted while busy SHALL be ignored, with no queuing.
REQ-024 start held high SHALL launch back-to-back divisions, the next one from the IDLE cycle that follows DONE.
REQ-025 Q, R and div_zero SHALL hold their values until the next DONE.
REQ-026 Changes on N and D after the start edge SHALL NOT affect the result in progress.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, Q=0, R=0, ready=0 and div_zero=0, and SHALL clear all internal registers and count.
REQ-028 Reset mid-RUN or in DONE SHALL abort the operation with no ready pulse; start SHALL be honoured on the first edge with reset=1.

Configuration
REQ-029 With macro DIV_ZERO_DETECT_EN defined, start with D=0 SHALL go directly from IDLE to DONE. At the next edge (E1) the block SHALL register Q=0, R=0, div_zero=1 and ready=1.
REQ-030 With DIV_ZERO_DETECT_EN defined, any DONE with D != 0 SHALL clear div_zero.
REQ-031 Without DIV_ZERO_DETECT_EN, div_zero SHALL be tied to 0. D=0 SHALL run the full 8 iterations, giving qmag=8'hFF and rmag=|N|[3:0], with the sign correction of REQ-016 and REQ-017 applied.
REQ-032 Without DIV_ZERO_DETECT_EN, D=0 SHALL therefore give Q=8'hFF for N>=0 and Q=8'h01 for N<0.

Verification
REQ-033 Scenario: N=100, D=7, start pulse -> ready at E9 with Q=14, R=2, busy high E1..E9.
REQ-034 Scenario: N=-100, D=7 -> Q=-14 (8'hF2), R=-2 (4'hE); N=100, D=-7 -> Q=-14, R=2; N=-100, D=-7 -> Q=14, R=-2.
REQ-035 Scenario: boundaries N=-128 with D=-8 -> Q=16, R=0; N=-128 with D=-1 -> Q=8'h80, R=0; N=127 with D=1 -> Q=127, R=0.
REQ-036 Scenario: D=0, N=50 -> with the macro: ready at E1, div_zero=1, Q=0, R=0; without the macro: ready at E9, Q=8'hFF, R=2, div_zero=0.
REQ-037 Scenario: start again at E3 during RUN -> ignored, single ready at E9; reset=0 at E5 -> no ready, all outputs 0, IDLE.
REQ-038 Scenario: start held high for 3 operations -> ready pulses at E9, E19 and E29, each with the correct Q and R; randomized sweep of all N and D != 0 -> N == Q*D + R except REQ-021.
